// File: rtl/seven_seg_display_ctrl_pkg.sv
// seven_seg_pkg: segment codes, mode/state/digit types and decode helper shared by the display controller
// No ports. Provides:
//   SEG_0..SEG_F, SEG_BLANK : active-low codes, bit order {g,f,e,d,c,b,a}
//   mode_e                  : MODE_HEX / MODE_DEC load rendering
//   state_e                 : IDLE / CONV / DONE controller states
//   digit_t                 : digit-register entry {blank, nibble}
//   seg_decode()            : digit entry to segment code
package seven_seg_pkg;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_LUT [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

    localparam int BCD_DIGITS = 10;

    typedef enum logic {MODE_HEX, MODE_DEC} mode_e;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

    typedef struct packed {
        logic       blank;
        logic [3:0] nib;
    } digit_t;

    function automatic logic [6:0] seg_decode(digit_t d);
        return d.blank ? SEG_BLANK : SEG_LUT[d.nib];
    endfunction
endpackage

// File: rtl/seven_seg_display_ctrl_if.sv
// seven_seg_display_ctrl_if: load/status/display bundle between a value source and the display controller
// Signals:
//   value_i   : 32-bit unsigned value to display
//   mode_i    : MODE_HEX / MODE_DEC, sampled with load_i
//   load_i    : load strobe, accepted only while busy_o = 0
//   busy_o    : decimal conversion in progress
//   ovf_o     : value does not fit in NUM_DIGITS digits
//   seg_o     : per-digit active-low codes, digit k at [7k+6:7k]
//   an_o      : one-hot active-low scan anode select
//   mux_seg_o : segment code of the currently scanned digit
// Modports: master drives the load side, slave is the controller.
interface seven_seg_display_ctrl_if
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic [31:0]             value_i;
    mode_e                   mode_i;
    logic                    load_i;
    logic                    busy_o;
    logic                    ovf_o;
    logic [7*NUM_DIGITS-1:0] seg_o;
    logic [NUM_DIGITS-1:0]   an_o;
    logic [6:0]              mux_seg_o;

    modport master (
        output value_i, mode_i, load_i,
        input  busy_o, ovf_o, seg_o, an_o, mux_seg_o
    );

    modport slave (
        input  value_i, mode_i, load_i,
        output busy_o, ovf_o, seg_o, an_o, mux_seg_o
    );
endinterface

// File: rtl/seven_seg_bin2bcd.sv
// seven_seg_bin2bcd: iterative double-dabble converter, 32-bit binary to 10-digit BCD, one step per cycle
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : latch bin_i and clear the accumulator; steps follow on the next 32 edges
//   bin_i    : 32-bit unsigned operand
//   done     : high in the cycle whose closing edge performs the 32nd step
//   bcd_o    : 40-bit BCD accumulator, final once the done edge has passed
module seven_seg_bin2bcd
    import seven_seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] bin_i,
    output logic        done,
    output logic [39:0] bcd_o
);
    logic [31:0] bin_q;
    logic [39:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q;
    logic        run_q;
    logic [3:0]  adj;
    logic        carry;

    // Adjust each digit, then shift the whole accumulator left with the
    // operand MSB entering digit 0; each digit's old bit 3 feeds the next.
    always_comb begin
        bcd_d = '0;
        carry = bin_q[31];
        for (int k = 0; k < BCD_DIGITS; k++) begin
            adj = (bcd_q[4*k+:4] >= 4'd5) ? bcd_q[4*k+:4] + 4'd3 : bcd_q[4*k+:4];
            bcd_d[4*k+:4] = {adj[2:0], carry};
            carry = adj[3];
        end
    end

    assign done  = run_q && (cnt_q == 5'd31);
    assign bcd_o = bcd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            bin_q <= bin_i;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            bin_q <= {bin_q[30:0], 1'b0};
            bcd_q <= bcd_d;
            cnt_q <= cnt_q + 5'd1;
            run_q <= !done;
        end
    end
endmodule

// File: rtl/seven_seg_display_ctrl.sv
// seven_seg_display_ctrl: N-digit hex/decimal seven-segment controller with registered codes and anode scan
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : seven_seg_display_ctrl_if.slave (value_i, mode_i, load_i in; busy_o, ovf_o, seg_o, an_o, mux_seg_o out)
// Parameters: NUM_DIGITS (1..8), CLK_DIV (cycles per scan slot, >= 1).
// Build option: define SEVEN_SEG_LZB_EN to blank leading zero digits on every digit-register write.
module seven_seg_display_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 1000
) (
    input logic                     clk,
    input logic                     rst,
    seven_seg_display_ctrl_if.slave bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_e                     state_q;
    logic                       busy_q, ovf_q;
    digit_t [NUM_DIGITS-1:0]    dig_q, wr_dig;
    logic [NUM_DIGITS-1:0][3:0] wr_nib;
    logic                       wr_ovf;
    logic [NUM_DIGITS-1:0][6:0] seg_q;
    logic                       conv_start, conv_done;
    logic [39:0]                bcd;
    logic [PW-1:0]              pre_q, pre_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic                       on_q, on_d, tc;
    logic [NUM_DIGITS-1:0]      an_q, an_d;
    logic [6:0]                 mux_q, mux_d;
`ifdef SEVEN_SEG_LZB_EN
    logic                       lead;
`endif

    assign conv_start = (state_q == IDLE) && bus.load_i && (bus.mode_i == MODE_DEC);

    seven_seg_bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin_i (bus.value_i),
        .done  (conv_done),
        .bcd_o (bcd)
    );

    // The only decimal write happens in DONE, every other write is a hex
    // load in IDLE, so one write path serves both sources.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            wr_nib[k] = (state_q == DONE) ? bcd[4*k+:4] : bus.value_i[4*k+:4];
            wr_dig[k] = '{blank: 1'b0, nib: wr_nib[k]};
        end
        wr_ovf = (state_q == DONE) ? |(bcd >> (4 * NUM_DIGITS)) : |(bus.value_i >> (4 * NUM_DIGITS));
`ifdef SEVEN_SEG_LZB_EN
        // Blank from the top down until the first nonzero digit; digit 0 always shows.
        lead = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            lead = lead & (wr_nib[k] == 4'd0);
            wr_dig[k].blank = lead;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dig_q   <= {NUM_DIGITS{5'b1_0000}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load_i && bus.mode_i == MODE_DEC) begin
                        state_q <= CONV;
                        busy_q  <= 1'b1;
                    end else if (bus.load_i) begin
                        dig_q <= wr_dig;
                        ovf_q <= wr_ovf;
                    end
                end
                CONV: state_q <= conv_done ? DONE : CONV;
                DONE: begin
                    dig_q   <= wr_dig;
                    ovf_q   <= wr_ovf;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= '1;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++)
                seg_q[k] <= seg_decode(dig_q[k]);
        end
    end

    // Anodes stay off until the first terminal count, which lights digit 0
    // without advancing; later terminal counts step the index.
    always_comb begin
        tc    = (pre_q == PW'(CLK_DIV - 1));
        pre_d = tc ? '0 : pre_q + PW'(1);
        idx_d = (tc && on_q) ? ((idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1)) : idx_q;
        on_d  = on_q | tc;
        an_d  = on_d ? ~(NUM_DIGITS'(1) << idx_d) : '1;
        mux_d = seg_q[idx_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
            on_q  <= 1'b0;
            an_q  <= '1;
            mux_q <= SEG_BLANK;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            on_q  <= on_d;
            an_q  <= an_d;
            mux_q <= mux_d;
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.ovf_o     = ovf_q;
    assign bus.seg_o     = seg_q;
    assign bus.an_o      = an_q;
    assign bus.mux_seg_o = mux_q;
endmodule
